dither_line_scheduler: RTL and testbench
========================================

# dither_line_scheduler

Sequencing controller for the three 8-bit line buffers that feed the error-diffusion dither stage. It tracks which buffer is being filled from the greyscale pixel stream, which holds the row being dithered and which holds the row receiving diffused error, and rotates these roles at line boundaries. It also generates the read address and the pipeline-aligned `a_valid`/`a_hcount`/`a_vcount` for the dither stage, and drains the last two rows after the final input line. It sits between the greyscale converter output and the line-buffer/dither datapath.

## Interface
- `FRAME_WIDTH`, 240, pixels per line; hcount range 0..FRAME_WIDTH-1
- `FRAME_HEIGHT`, 320, lines per frame; vcount range 0..FRAME_HEIGHT-1
- `READ_LATENCY`, 2, BRAM read latency in cycles, from address to data

- `clk_in`, input, 1, single system clock
- `rst_n_in`, input, 1, asynchronous, active-low reset
- `bw_pixel_valid`, input, 1, an incoming greyscale pixel is present this cycle
- `bw_hcount`, input, 11, column of the incoming pixel
- `bw_vcount`, input, 10, row of the incoming pixel
- `bw_ready`, output, 1, scheduler accepts input; a pixel transfers when valid & ready
- `fill_sel`, output, 3, one-hot; buffer written with incoming pixels at address `bw_hcount`
- `cur_sel`, output, 3, one-hot; buffer holding the row being dithered (source of b)
- `nxt_sel`, output, 3, one-hot; buffer holding the row below, which receives error (source of e)
- `rd_addr`, output, 11, read address presented to `cur_sel` and `nxt_sel` this cycle
- `rd_req`, output, 1, `rd_addr` is a live dither request
- `a_valid`, output, 1, b/e data for (`a_hcount`, `a_vcount`) is on the buffer outputs
- `a_hcount`, output, 11, column of the pixel being dithered
- `a_vcount`, output, 10, row of the pixel being dithered
- `frame_done`, output, 1, one-cycle pulse after the last drained pixel request
- `sync_err`, output, 1, one-cycle pulse on an unexpected frame restart

## Operation
- Rotation counter `rot` is 0..2. `fill_sel = 1<<rot`, `cur_sel = 1<<((rot+1)%3)`, `nxt_sel = 1<<((rot+2)%3)`.
- `rot` advances (2 wraps to 0) on the accepted pixel with hcount = FRAME_WIDTH-1 in PRIME and RUN, and on the last synthesized column of each line in DRAIN.
- States:
  - IDLE: `bw_ready`=1. An accepted pixel at (0,0) is written and moves the block to PRIME. Any other accepted pixel is ignored: no rotation, no request.
  - PRIME: rows 0 and 1 are filled only. `rd_req`=0. After row 1, column FRAME_WIDTH-1 is accepted, go to RUN.
  - RUN: each accepted pixel (h,v) drives `rd_addr`=h and `rd_req`=1 for dither row v-2. When (FRAME_WIDTH-1, FRAME_HEIGHT-1) is accepted, go to DRAIN.
  - DRAIN: `bw_ready`=0. An internal column counter runs 0..FRAME_WIDTH-1 once per cycle, two passes, with `rd_req`=1 for rows FRAME_HEIGHT-2 and FRAME_HEIGHT-1. After the final request, pulse `frame_done` and go to IDLE.
- Resync: in PRIME or RUN, an accepted pixel at (0,0) sets `rot`=0, pulses `sync_err`, enters PRIME and is written as row 0. Requests already in flight still complete.
- Gaps in `bw_pixel_valid` stall the sequence. Nothing advances without an accepted pixel, except in DRAIN.
- Widths: `a_vcount` = v-2, computed in 10 bits; it is never negative in RUN. `rd_addr` is zero-extended hcount.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `rot`=0, `fill_sel`=001, `cur_sel`=010, `nxt_sel`=100, `bw_ready`=1, `rd_addr`=0, `rd_req`=0, `a_valid`=0, `a_hcount`=0, `a_vcount`=0, `frame_done`=0, `sync_err`=0.
- Reset mid-frame discards all in-flight requests. `a_valid` drops at once.
- `fill_sel`, `cur_sel`, `nxt_sel`, `rd_addr`, `rd_req` and `bw_ready` are combinational from state and input, so they are valid in the cycle of the accepted pixel.
- `a_valid`, `a_hcount` and `a_vcount` equal `rd_req` and its coordinates delayed by exactly READ_LATENCY cycles, through a shift register.
- Selects reflect `rot` at request time. Rotation takes effect the cycle after the end-of-line pixel.
- DRAIN entry: the first drained request is the cycle after the last accepted input pixel.

## Test plan
- Reset values: assert `rst_n_in`=0 mid-RUN → all outputs take their reset values the same cycle; after release, `bw_ready`=1 and selects are 001/010/100.
- Prime: stream rows 0–1 (480 valid pixels, no gaps) → `rd_req` and `a_valid` stay 0; afterwards `fill_sel`=100 and `cur_sel`=001.
- Run alignment: pixel (5,2) accepted at cycle t → `rd_req`=1 and `rd_addr`=5 at t; `a_valid`=1, `a_hcount`=5, `a_vcount`=0 at t+2.
- Stall: a valid pattern of 1,0,0,1 on row 3 → `a_valid` follows the same pattern shifted by 2; `rot` unchanged until column 239 is accepted.
- Drain: accept (239,319) → `bw_ready`=0 for 480 cycles; `a_vcount` is 318 then 319; `frame_done` pulses once, then state is IDLE.
- Resync: pixel (0,0) arrives during row 100 → `sync_err` pulses; selects are 001/010/100; the next 480 pixels produce no `rd_req`.

Source files
------------

// File: rtl/dither_line_scheduler_if.sv
// Bundle between the greyscale pixel source, the line-buffer/dither datapath
// and the line scheduler. The scheduler takes the slave side.
interface dither_line_scheduler_if;
  logic        bw_pixel_valid;
  logic [10:0] bw_hcount;
  logic [9:0]  bw_vcount;
  logic        bw_ready;
  logic [2:0]  fill_sel;
  logic [2:0]  cur_sel;
  logic [2:0]  nxt_sel;
  logic [10:0] rd_addr;
  logic        rd_req;
  logic        a_valid;
  logic [10:0] a_hcount;
  logic [9:0]  a_vcount;
  logic        frame_done;
  logic        sync_err;

  modport master (
    output bw_pixel_valid, bw_hcount, bw_vcount,
    input  bw_ready, fill_sel, cur_sel, nxt_sel, rd_addr, rd_req,
           a_valid, a_hcount, a_vcount, frame_done, sync_err
  );

  modport slave (
    input  bw_pixel_valid, bw_hcount, bw_vcount,
    output bw_ready, fill_sel, cur_sel, nxt_sel, rd_addr, rd_req,
           a_valid, a_hcount, a_vcount, frame_done, sync_err
  );
endinterface

// File: rtl/dither_line_scheduler.sv
// Rotates fill/current/next roles over three line buffers and issues dither
// read requests, with READ_LATENCY-aligned a_* outputs and a two-row drain.
module dither_line_scheduler #(
  parameter int FRAME_WIDTH  = 240,
  parameter int FRAME_HEIGHT = 320,
  parameter int READ_LATENCY = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  dither_line_scheduler_if.slave   bus
);

  localparam logic [10:0] LAST_COL   = 11'(FRAME_WIDTH - 1);
  localparam logic [9:0]  LAST_ROW   = 10'(FRAME_HEIGHT - 1);
  localparam logic [9:0]  DRAIN_ROW0 = 10'(FRAME_HEIGHT - 2);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [1:0]  rot_q, rot_d, rot_inc, rot_eff;
  logic [10:0] col_q, col_d;
  logic        pass_q, pass_d;
  logic        frame_done_q, frame_done_d;
  logic        sync_err_q, sync_err_d;

  logic        accept, sof, eol, feeding;
  logic        req;
  logic [10:0] req_h;
  logic [9:0]  req_v;

  assign accept  = bus.bw_pixel_valid & bus.bw_ready;
  assign sof     = accept && (bus.bw_hcount == 11'd0) && (bus.bw_vcount == 10'd0);
  assign eol     = accept && (bus.bw_hcount == LAST_COL);
  assign feeding = (state_q == S_PRIME) || (state_q == S_RUN);
  assign rot_inc = (rot_q == 2'd2) ? 2'd0 : rot_q + 2'd1;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      rot_q        <= 2'd0;
      col_q        <= 11'd0;
      pass_q       <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rot_q        <= rot_d;
      col_q        <= col_d;
      pass_q       <= pass_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rot_d        = rot_q;
    col_d        = col_q;
    pass_d       = pass_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (sof) state_d = S_PRIME;
      S_PRIME, S_RUN: begin
        if (sof) begin
          state_d    = S_PRIME;
          rot_d      = 2'd0;
          sync_err_d = 1'b1;
        end else if (eol) begin
          rot_d = rot_inc;
          if (state_q == S_PRIME && bus.bw_vcount == 10'd1) state_d = S_RUN;
          if (state_q == S_RUN && bus.bw_vcount == LAST_ROW) begin
            state_d = S_DRAIN;
            col_d   = 11'd0;
            pass_d  = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (col_q == LAST_COL) begin
          col_d  = 11'd0;
          pass_d = ~pass_q;
          rot_d  = rot_inc;
          if (pass_q) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        end else begin
          col_d = col_q + 11'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A resync pixel must already land in buffer 0, so the selects see rot=0 now.
  always_comb begin
    bus.bw_ready = (state_q != S_DRAIN);
    rot_eff      = (feeding && sof) ? 2'd0 : rot_q;
    req          = 1'b0;
    req_h        = 11'd0;
    req_v        = 10'd0;
    case (rot_eff)
      2'd1:    begin bus.fill_sel = 3'b010; bus.cur_sel = 3'b100; bus.nxt_sel = 3'b001; end
      2'd2:    begin bus.fill_sel = 3'b100; bus.cur_sel = 3'b001; bus.nxt_sel = 3'b010; end
      default: begin bus.fill_sel = 3'b001; bus.cur_sel = 3'b010; bus.nxt_sel = 3'b100; end
    endcase
    if (state_q == S_RUN && accept && !sof) begin
      req   = 1'b1;
      req_h = bus.bw_hcount;
      req_v = bus.bw_vcount - 10'd2;
    end else if (state_q == S_DRAIN) begin
      req   = 1'b1;
      req_h = col_q;
      req_v = DRAIN_ROW0 + {9'd0, pass_q};
    end
    bus.rd_req  = req;
    bus.rd_addr = req_h;
  end

  logic        pipe_vld_q [READ_LATENCY];
  logic [10:0] pipe_h_q   [READ_LATENCY];
  logic [9:0]  pipe_v_q   [READ_LATENCY];

  genvar gi;
  generate
    for (gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
      logic        vld_d;
      logic [10:0] h_d;
      logic [9:0]  v_d;
      if (gi == 0) begin : g_head
        assign vld_d = req;
        assign h_d   = req_h;
        assign v_d   = req_v;
      end else begin : g_tail
        assign vld_d = pipe_vld_q[gi-1];
        assign h_d   = pipe_h_q[gi-1];
        assign v_d   = pipe_v_q[gi-1];
      end
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          pipe_vld_q[gi] <= 1'b0;
          pipe_h_q[gi]   <= 11'd0;
          pipe_v_q[gi]   <= 10'd0;
        end else begin
          pipe_vld_q[gi] <= vld_d;
          pipe_h_q[gi]   <= h_d;
          pipe_v_q[gi]   <= v_d;
        end
      end
    end
  endgenerate

  assign bus.a_valid    = pipe_vld_q[READ_LATENCY-1];
  assign bus.a_hcount   = pipe_h_q[READ_LATENCY-1];
  assign bus.a_vcount   = pipe_v_q[READ_LATENCY-1];
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_dither_line_scheduler.sv
// Directed bench for dither_line_scheduler: reset, prime, alignment, stall,
// resync, drain and mid-frame reset, with hand-computed expectations.
module tb_dither_line_scheduler;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  dither_line_scheduler_if bus_if ();

  dither_line_scheduler #(
    .FRAME_WIDTH (240),
    .FRAME_HEIGHT(320),
    .READ_LATENCY(2)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus_if)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Apply inputs on the falling edge; return 1 time unit later so combinational
  // outputs have settled and registered outputs show the last rising edge.
  task automatic drive(input logic vld, input int h, input int vc);
    @(negedge clk_in);
    bus_if.bw_pixel_valid = vld;
    bus_if.bw_hcount      = 11'(h);
    bus_if.bw_vcount      = 10'(vc);
    #1;
  endtask

  task automatic stream_row(input int vc, input int h0, input int h1,
                            output int reqs, output int avs);
    reqs = 0;
    avs  = 0;
    for (int h = h0; h <= h1; h++) begin
      drive(1'b1, h, vc);
      if (bus_if.rd_req)  reqs++;
      if (bus_if.a_valid) avs++;
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_bw_ready"},   32'(bus_if.bw_ready),   32'd1);
    chk({pfx, "_fill_sel"},   32'(bus_if.fill_sel),   32'b001);
    chk({pfx, "_cur_sel"},    32'(bus_if.cur_sel),    32'b010);
    chk({pfx, "_nxt_sel"},    32'(bus_if.nxt_sel),    32'b100);
    chk({pfx, "_rd_addr"},    32'(bus_if.rd_addr),    32'd0);
    chk({pfx, "_rd_req"},     32'(bus_if.rd_req),     32'd0);
    chk({pfx, "_a_valid"},    32'(bus_if.a_valid),    32'd0);
    chk({pfx, "_a_hcount"},   32'(bus_if.a_hcount),   32'd0);
    chk({pfx, "_a_vcount"},   32'(bus_if.a_vcount),   32'd0);
    chk({pfx, "_frame_done"}, 32'(bus_if.frame_done), 32'd0);
    chk({pfx, "_sync_err"},   32'(bus_if.sync_err),   32'd0);
  endtask

  initial begin
    int reqs, avs, r2, a2;
    int hh, nready_lo, ndone, done_k;
    logic [9:0] av_at1, av_at2, av_at242;
    logic stall_pat [6];
    logic stall_av  [6];
    logic stall_req1;
    logic d0_req;
    logic [10:0] d0_addr, d479_addr;

    bus_if.bw_pixel_valid = 1'b0;
    bus_if.bw_hcount      = 11'd0;
    bus_if.bw_vcount      = 10'd0;

    // Power-on reset
    #12;
    chk_reset_outputs("por");
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // IDLE ignores anything but (0,0)
    drive(1'b1, 5, 3);
    chk("idle_ignore_req", 32'(bus_if.rd_req), 32'd0);
    drive(1'b1, 239, 3);
    drive(1'b0, 0, 0);
    chk("idle_no_rot_fill", 32'(bus_if.fill_sel), 32'b001);

    // Prime rows 0 and 1
    stream_row(0, 0, 239, reqs, avs);
    stream_row(1, 0, 239, r2, a2);
    chk("prime_rd_req_count",  32'(reqs + r2), 32'd0);
    chk("prime_a_valid_count", 32'(avs + a2),  32'd0);
    drive(1'b0, 0, 0);
    chk("prime_fill_sel", 32'(bus_if.fill_sel), 32'b100);
    chk("prime_cur_sel",  32'(bus_if.cur_sel),  32'b001);
    chk("prime_nxt_sel",  32'(bus_if.nxt_sel),  32'b010);

    // Run alignment on pixel (5,2)
    stream_row(2, 0, 4, reqs, avs);
    drive(1'b1, 5, 2);
    chk("run_rd_req",  32'(bus_if.rd_req),  32'd1);
    chk("run_rd_addr", 32'(bus_if.rd_addr), 32'd5);
    chk("run_cur_sel", 32'(bus_if.cur_sel), 32'b001);
    drive(1'b1, 6, 2);
    drive(1'b1, 7, 2);
    chk("run_a_valid",  32'(bus_if.a_valid),  32'd1);
    chk("run_a_hcount", 32'(bus_if.a_hcount), 32'd5);
    chk("run_a_vcount", 32'(bus_if.a_vcount), 32'd0);
    stream_row(2, 8, 239, reqs, avs);
    chk("row2_rd_req_count", 32'(reqs), 32'd232);

    // Stall pattern 1,0,0,1 on row 3
    stall_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    hh = 0;
    for (int k = 0; k < 6; k++) begin
      drive(stall_pat[k], hh, 3);
      stall_av[k] = bus_if.a_valid;
      if (k == 1) stall_req1 = bus_if.rd_req;
      if (stall_pat[k]) hh++;
    end
    chk("stall_gap_rd_req", 32'(stall_req1), 32'd0);
    for (int k = 2; k < 6; k++)
      chk($sformatf("stall_a_valid_%0d", k), 32'(stall_av[k]), 32'(stall_pat[k-2]));
    chk("stall_fill_sel", 32'(bus_if.fill_sel), 32'b001);
    stream_row(3, 2, 238, reqs, avs);
    drive(1'b1, 239, 3);
    chk("eol_cycle_fill_sel", 32'(bus_if.fill_sel), 32'b001);
    drive(1'b0, 0, 0);
    chk("after_eol_fill_sel", 32'(bus_if.fill_sel), 32'b010);

    // Resync during row 100
    stream_row(100, 0, 9, reqs, avs);
    drive(1'b1, 0, 0);
    chk("resync_fill_sel", 32'(bus_if.fill_sel), 32'b001);
    chk("resync_cur_sel",  32'(bus_if.cur_sel),  32'b010);
    chk("resync_nxt_sel",  32'(bus_if.nxt_sel),  32'b100);
    chk("resync_rd_req",   32'(bus_if.rd_req),   32'd0);
    drive(1'b1, 1, 0);
    chk("resync_sync_err",       32'(bus_if.sync_err), 32'd1);
    chk("resync_inflight_valid", 32'(bus_if.a_valid),  32'd1);
    chk("resync_inflight_h",     32'(bus_if.a_hcount), 32'd9);
    chk("resync_inflight_v",     32'(bus_if.a_vcount), 32'd98);
    drive(1'b1, 2, 0);
    chk("resync_sync_err_once", 32'(bus_if.sync_err), 32'd0);
    stream_row(0, 3, 239, reqs, avs);
    stream_row(1, 0, 239, r2, a2);
    chk("resync_prime_rd_req_count", 32'(reqs + r2), 32'd0);

    // Jump to the final pixel and drain
    stream_row(2, 0, 3, reqs, avs);
    drive(1'b1, 239, 319);
    chk("last_rd_req",  32'(bus_if.rd_req),  32'd1);
    chk("last_rd_addr", 32'(bus_if.rd_addr), 32'd239);
    nready_lo = 0;
    ndone     = 0;
    done_k    = -1;
    for (int k = 0; k < 482; k++) begin
      drive(1'b1, k % 240, 5);
      if (!bus_if.bw_ready) nready_lo++;
      if (bus_if.frame_done) begin
        ndone++;
        done_k = k;
      end
      if (k == 0) begin d0_req = bus_if.rd_req; d0_addr = bus_if.rd_addr; end
      if (k == 1) av_at1 = bus_if.a_vcount;
      if (k == 2) av_at2 = bus_if.a_vcount;
      if (k == 242) av_at242 = bus_if.a_vcount;
      if (k == 479) d479_addr = bus_if.rd_addr;
    end
    chk("drain_first_req",      32'(d0_req),    32'd1);
    chk("drain_first_addr",     32'(d0_addr),   32'd0);
    chk("drain_last_addr",      32'(d479_addr), 32'd239);
    chk("drain_ready_low",      32'(nready_lo), 32'd480);
    chk("drain_last_in_vcount", 32'(av_at1),    32'd317);
    chk("drain_pass0_vcount",   32'(av_at2),    32'd318);
    chk("drain_pass1_vcount",   32'(av_at242),  32'd319);
    chk("frame_done_count",     32'(ndone),     32'd1);
    chk("frame_done_cycle",     32'(done_k),    32'd480);
    drive(1'b1, 7, 9);
    chk("post_drain_bw_ready", 32'(bus_if.bw_ready), 32'd1);
    chk("post_drain_rd_req",   32'(bus_if.rd_req),   32'd0);

    // Reset in the middle of RUN
    drive(1'b1, 0, 0);
    stream_row(0, 1, 239, reqs, avs);
    stream_row(1, 0, 239, reqs, avs);
    stream_row(2, 0, 10, reqs, avs);
    chk("prereset_a_valid", 32'(bus_if.a_valid), 32'd1);
    @(negedge clk_in);
    bus_if.bw_hcount = 11'd11;
    rst_n_in = 1'b0;
    #1;
    chk_reset_outputs("midrun");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    drive(1'b1, 12, 2);
    chk("release_bw_ready", 32'(bus_if.bw_ready), 32'd1);
    chk("release_rd_req",   32'(bus_if.rd_req),   32'd0);
    chk("release_fill_sel", 32'(bus_if.fill_sel), 32'b001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
